ram_port_arbiter: RTL and testbench

- Shares one RAM port (32k x 32, byte-write) between the instruction-fetch requester (read-only) and the load/store requester (read/write).
- Sequences each access through the RAM port's request/ready/read-valid handshake and returns read data or write completion to the owning requester.
- Fair two-way arbitration and a per-access timeout.
- Sits between the core's fetch/LSU units and the RAM I/O wrapper.

---
 rtl/ram_port_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Shares one byte-write RAM port between the fetch (read-only) and LSU (read/write) requesters.
// Define ARB_PERF_EN to add saturating grant and timeout counters.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic                d_wdone,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  output logic                owner,
`ifdef ARB_PERF_EN
  output logic [31:0]         i_grant_cnt,
  output logic [31:0]         d_grant_cnt,
  output logic [15:0]         to_cnt,
`endif
  output logic                ram_req,
  output logic [DATA_W/8-1:0] ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic                ram_ready,
  input  logic                ram_rvalid,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    WAIT_WR = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic              owner_q, owner_d;
  logic [BE_W-1:0]   ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              seen_low_q, seen_low_d;
  logic              ram_req_q, ram_req_d;
  logic              i_gnt_q, i_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              i_rvalid_q, i_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic              d_wdone_q, d_wdone_d;
  logic              err_q, err_d;

  logic start_c;
  logic lsu_wins_c;
  logic first_wait_c;
  logic wr_done_c;
  logic timeout_c;

  // LSU wins when alone, or on contention when fetch owned the previous access
  assign start_c      = ram_ready && (i_req || d_req);
  assign lsu_wins_c   = d_req && (!i_req || !owner_q);
  assign first_wait_c = (cnt_q == '0);
  // RAM ready is registered on its side, so only a low-then-high seen after the first cycle means done
  assign wr_done_c    = !first_wait_c && ram_ready && seen_low_q;
  assign timeout_c    = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_c) state_d = ISSUE;
      ISSUE:   state_d = (ram_we_q != '0) ? WAIT_WR : WAIT_RD;
      WAIT_RD: if (ram_rvalid || timeout_c) state_d = IDLE;
      WAIT_WR: if (wr_done_c || timeout_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    seen_low_d  = seen_low_q;
    ram_req_d   = 1'b0;
    i_gnt_d     = 1'b0;
    d_gnt_d     = 1'b0;
    i_rvalid_d  = 1'b0;
    d_rvalid_d  = 1'b0;
    d_wdone_d   = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          owner_d   = lsu_wins_c;
          ram_req_d = 1'b1;
          i_gnt_d   = !lsu_wins_c;
          d_gnt_d   = lsu_wins_c;
          if (lsu_wins_c) begin
            ram_addr_d  = d_addr;
            ram_we_d    = d_we;
            ram_wdata_d = d_wdata;
          end else begin
            ram_addr_d  = i_addr;
            ram_we_d    = '0;
            ram_wdata_d = '0;
          end
        end
      end
      ISSUE: begin
        cnt_d      = '0;
        seen_low_d = 1'b0;
      end
      WAIT_RD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ram_rvalid) begin
          rdata_d    = ram_rdata;
          i_rvalid_d = !owner_q;
          d_rvalid_d = owner_q;
        end else if (timeout_c) begin
          err_d = 1'b1;
        end
      end
      WAIT_WR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!first_wait_c && !ram_ready) seen_low_d = 1'b1;
        if (wr_done_c) begin
          d_wdone_d = 1'b1;
        end else if (timeout_c) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= 1'b0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      seen_low_q  <= 1'b0;
      ram_req_q   <= 1'b0;
      i_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_wdone_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      seen_low_q  <= seen_low_d;
      ram_req_q   <= ram_req_d;
      i_gnt_q     <= i_gnt_d;
      d_gnt_q     <= d_gnt_d;
      i_rvalid_q  <= i_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      d_wdone_q   <= d_wdone_d;
      err_q       <= err_d;
    end
  end

  assign i_gnt     = i_gnt_q;
  assign i_rvalid  = i_rvalid_q;
  assign d_gnt     = d_gnt_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_wdone   = d_wdone_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign owner     = owner_q;
  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

`ifdef ARB_PERF_EN
  logic [31:0] i_grant_cnt_q;
  logic [31:0] d_grant_cnt_q;
  logic [15:0] to_cnt_q;

  // Saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_grant_cnt_q <= '0;
      d_grant_cnt_q <= '0;
      to_cnt_q      <= '0;
    end else begin
      if (i_gnt_q && (i_grant_cnt_q != '1)) i_grant_cnt_q <= i_grant_cnt_q + 32'd1;
      if (d_gnt_q && (d_grant_cnt_q != '1)) d_grant_cnt_q <= d_grant_cnt_q + 32'd1;
      if (err_q && (to_cnt_q != '1))        to_cnt_q      <= to_cnt_q + 16'd1;
    end
  end

  assign i_grant_cnt = i_grant_cnt_q;
  assign d_grant_cnt = d_grant_cnt_q;
  assign to_cnt      = to_cnt_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed plus randomized bench for ram_port_arbiter against a transaction-level model.
module tb_ram_port_arbiter;

  localparam int unsigned AW   = 15;
  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = DW / 8;
  localparam int unsigned TOUT = 8;

  logic          clk;
  logic          rst_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic          d_req;
  logic [BW-1:0] d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic          d_wdone;
  logic [DW-1:0] rdata;
  logic          err;
  logic          owner;
  logic          ram_req;
  logic [BW-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_ready;
  logic          ram_rvalid;
  logic [DW-1:0] ram_rdata;
`ifdef ARB_PERF_EN
  logic [31:0]   i_grant_cnt;
  logic [31:0]   d_grant_cnt;
  logic [15:0]   to_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: last granted requester and last successfully read word
  logic          m_owner;
  logic [DW-1:0] m_rdata;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_gnt      (i_gnt),
    .i_rvalid   (i_rvalid),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_wdone    (d_wdone),
    .rdata      (rdata),
    .err        (err),
    .owner      (owner),
`ifdef ARB_PERF_EN
    .i_grant_cnt(i_grant_cnt),
    .d_grant_cnt(d_grant_cnt),
    .to_cnt     (to_cnt),
`endif
    .ram_req    (ram_req),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_ready  (ram_ready),
    .ram_rvalid (ram_rvalid),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] pulses();
    return {ram_req, i_gnt, d_gnt, i_rvalid, d_rvalid, d_wdone, err};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pulses"}, 64'(pulses()), 64'(0));
    chk({tag, "_rdata"},  64'(rdata),    64'(0));
    chk({tag, "_owner"},  64'(owner),    64'(0));
    chk({tag, "_ram_we"}, 64'(ram_we),   64'(0));
    chk({tag, "_ram_addr"}, 64'(ram_addr), 64'(0));
    chk({tag, "_ram_wdata"}, 64'(ram_wdata), 64'(0));
  endtask

  // One complete access: rv_v/rdy_v give ram_rvalid/ram_ready per wait cycle (bit k = wait cycle k)
  task automatic access(input logic ir, input logic dr,
                        input logic [AW-1:0] ia, input logic [AW-1:0] da,
                        input logic [BW-1:0] dwe, input logic [DW-1:0] dwd,
                        input logic hold,
                        input logic [TOUT:1] rv_v, input logic [TOUT:1] rdy_v,
                        input logic [DW-1:0] rd_word);
    logic w, wr, seen, rd_ok, wr_ok;
    int done_k, last;
    logic [AW-1:0] exp_addr;
    w  = dr && (!ir || !m_owner);
    wr = w && (dwe != '0);
    exp_addr = w ? da : ia;
    done_k = 0;
    seen = 1'b0;
    for (int k = 1; k <= int'(TOUT); k++) begin
      if (done_k == 0) begin
        if (!wr) begin
          if (rv_v[k]) done_k = k;
        end else if (k >= 2) begin
          if (rdy_v[k] && seen) done_k = k;
          else if (!rdy_v[k]) seen = 1'b1;
        end
      end
    end
    last  = (done_k != 0) ? done_k : int'(TOUT);
    rd_ok = !wr && (done_k != 0);
    wr_ok = wr && (done_k != 0);

    i_req = ir; d_req = dr; i_addr = ia; d_addr = da; d_we = dwe; d_wdata = dwd;
    ram_ready = 1'b1; ram_rvalid = 1'b0;
    cyc();
    chk("issue_pulses", 64'(pulses()), 64'({1'b1, !w, w, 4'b0000}));
    chk("issue_owner", 64'(owner), 64'(w));
    chk("issue_addr", 64'(ram_addr), 64'(exp_addr));
    chk("issue_we", 64'(ram_we), 64'(w ? dwe : '0));
    chk("issue_wdata", 64'(ram_wdata), 64'(w ? dwd : '0));
    m_owner = w;
    if (!hold) begin
      i_req = 1'b0; d_req = 1'b0;
      i_addr = AW'($urandom); d_addr = AW'($urandom); d_wdata = $urandom;
    end
    ram_rvalid = 1'($urandom);
    ram_rdata  = $urandom;
    for (int k = 1; k <= last; k++) begin
      cyc();
      chk("wait_quiet", 64'(pulses()), 64'(0));
      ram_rvalid = wr ? 1'($urandom) : rv_v[k];
      ram_rdata  = (rd_ok && k == done_k) ? rd_word : $urandom;
      ram_ready  = wr ? rdy_v[k] : 1'($urandom);
    end
    cyc();
    ram_rvalid = 1'b0;
    ram_ready  = 1'b1;
    if (rd_ok) m_rdata = rd_word;
    chk("done_pulses", 64'(pulses()),
        64'({3'b000, rd_ok && !w, rd_ok && w, wr_ok, done_k == 0}));
    chk("done_rdata", 64'(rdata), 64'(m_rdata));
    chk("done_addr_held", 64'(ram_addr), 64'(exp_addr));
  endtask

  initial begin
    logic [3:0] ord;
    logic ir, dr;
    logic [BW-1:0] dwe;

    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0;
    d_we = '0; d_wdata = '0; ram_ready = 1'b1; ram_rvalid = 1'b0; ram_rdata = '0;
    m_owner = 1'b0; m_rdata = '0;
    cyc(); cyc();
    chk_all_zero("reset");
    rst_n = 1'b1;
    cyc();
    chk("idle_quiet", 64'(pulses()), 64'(0));

    // Fetch-only read returning on the third wait cycle
    access(1'b1, 1'b0, 15'h0010, 15'h0000, 4'h0, 32'h0, 1'b0,
           8'b0000_0100, 8'hFF, 32'hDEADBEEF);
    cyc();
    chk("fetch_rvalid_one_cycle", 64'(pulses()), 64'(0));

    // LSU byte store: ready high, low, low, then high
    access(1'b0, 1'b1, 15'h0000, 15'h7FFF, 4'b0010, 32'h0000AB00, 1'b0,
           8'b0000_0000, 8'b1111_1001, 32'h0);

    // Contention from reset: grants alternate starting with the LSU
    i_req = 1'b1; d_req = 1'b1; d_we = '0;
    rst_n = 1'b0;
    #1;
    m_owner = 1'b0; m_rdata = '0;
    chk_all_zero("reset2");
    cyc();
    rst_n = 1'b1;
    ord = 4'b0101;
    for (int n = 0; n < 4; n++) begin
      access(1'b1, 1'b1, AW'(15'h0100 + n), AW'(15'h0200 + n), 4'h0, 32'h0, 1'b1,
             TOUT'(1 << n[0]), 8'h00, 32'hC0DE_0000 + n);
      chk("contention_owner", 64'(owner), 64'(ord[n]));
    end
    i_req = 1'b0; d_req = 1'b0;

    // RAM busy: request is ignored while ready is low
    i_req = 1'b1; i_addr = 15'h0222; ram_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      cyc();
      chk("busy_quiet", 64'(pulses()), 64'(0));
    end
    access(1'b1, 1'b0, 15'h0222, 15'h0, 4'h0, 32'h0, 1'b0,
           8'b0000_0001, 8'h00, 32'h1234_5678);

    // Read timeout, then a write whose only low ready falls in the ignored first cycle
    access(1'b1, 1'b0, 15'h0333, 15'h0, 4'h0, 32'h0, 1'b0,
           8'h00, 8'h00, 32'hBAD0_BAD0);
    access(1'b0, 1'b1, 15'h0, 15'h0444, 4'hF, 32'hFEED_F00D, 1'b0,
           8'h00, 8'b1111_1110, 32'h0);

    for (int n = 0; n < 40; n++) begin
      ir = 1'($urandom);
      dr = 1'($urandom);
      if (!ir && !dr) dr = 1'b1;
      dwe = 1'($urandom) ? BW'($urandom) : '0;
      access(ir, dr, AW'($urandom), AW'($urandom), dwe, $urandom, 1'b0,
             TOUT'($urandom & $urandom & $urandom), TOUT'($urandom), $urandom);
    end

    // Known read so the mid-access reset has state to clear
    access(1'b0, 1'b1, 15'h0, 15'h0555, 4'h0, 32'h0, 1'b0,
           8'b0000_0010, 8'h00, 32'hA5A5_0001);
    d_req = 1'b1; d_addr = 15'h1234; d_we = '0; ram_ready = 1'b1;
    cyc();
    chk("midrst_issue", 64'(d_gnt), 64'(1));
    d_req = 1'b0;
    cyc(); cyc();
    rst_n = 1'b0;
    #1;
    m_owner = 1'b0; m_rdata = '0;
    chk_all_zero("midrst");
    cyc();
    rst_n = 1'b1;
    ram_rvalid = 1'b1; ram_rdata = 32'h5A5A_5A5A;
    cyc();
    chk("late_rvalid_pulses", 64'(pulses()), 64'(0));
    chk("late_rvalid_rdata", 64'(rdata), 64'(0));
    ram_rvalid = 1'b0;
    cyc();
    chk("late_rvalid_quiet", 64'(pulses()), 64'(0));
    access(1'b1, 1'b0, 15'h0777, 15'h0, 4'h0, 32'h0, 1'b0,
           8'b0000_1000, 8'h00, 32'h0BAD_CAFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
